// File: rtl/hs_fifo.sv
// rtl/hs_fifo.sv - first-word-fall-through FIFO, push side in, pull side out (optional HS_FIFO_ERR_EN adds sticky ovf/udf)
module hs_fifo #(
  parameter  int DWIDTH = 32,
  parameter  int DEPTH  = 4,
  localparam int LWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              push_rdy,
  input  logic              push_push,
  input  logic [DWIDTH-1:0] push_dat,
  output logic              pull_rdy,
  input  logic              pull_pop,
  output logic [DWIDTH-1:0] pull_dat,
  output logic [LWIDTH-1:0] level
`ifdef HS_FIFO_ERR_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);

  localparam int PWIDTH = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PWIDTH-1:0] wr_ptr;
  logic [PWIDTH-1:0] rd_ptr;
  logic [LWIDTH-1:0] level_nxt;
  logic              push_acc;
  logic              pop_acc;

  // Only requests qualified by the registered ready flags take effect.
  assign push_acc = push_push & push_rdy;
  assign pop_acc  = pull_pop & pull_rdy;

  // Head word is read straight from storage at the read pointer.
  assign pull_dat = mem[rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_nxt = level;
    if (push_acc && !pop_acc) begin
      level_nxt = level + LWIDTH'(1);
    end else if (pop_acc && !push_acc) begin
      level_nxt = level - LWIDTH'(1);
    end
  end

  // Pointers, occupancy and the registered ready flags derived from next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      push_rdy <= 1'b0;
      pull_rdy <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= (wr_ptr == PWIDTH'(DEPTH - 1)) ? '0 : wr_ptr + PWIDTH'(1);
      end
      if (pop_acc) begin
        rd_ptr <= (rd_ptr == PWIDTH'(DEPTH - 1)) ? '0 : rd_ptr + PWIDTH'(1);
      end
      level    <= level_nxt;
      push_rdy <= (level_nxt != LWIDTH'(DEPTH));
      pull_rdy <= (level_nxt != '0);
    end
  end

  // Storage is written on accepted pushes only and is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_dat;
    end
  end

`ifdef HS_FIFO_ERR_EN
  // Sticky flags for requests made while the corresponding side was not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push_push && !push_rdy) begin
        ovf <= 1'b1;
      end
      if (pull_pop && !pull_rdy) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hs_fifo.sv
// tb/tb_hs_fifo.sv - self-checking bench for hs_fifo, DEPTH=4 and DEPTH=3 instances driven in parallel
module tb_hs_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_push = 1'b0;
  logic [31:0] push_dat = '0;
  logic        pull_pop = 1'b0;

  logic        push_rdy4, pull_rdy4;
  logic [31:0] pull_dat4;
  logic [2:0]  level4;
  logic        push_rdy3, pull_rdy3;
  logic [31:0] pull_dat3;
  logic [1:0]  level3;
`ifdef HS_FIFO_ERR_EN
  logic        ovf4, udf4, ovf3, udf3;
  logic        ovf_m4, udf_m4, ovf_m3, udf_m3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q4 [$];
  logic [31:0] q3 [$];
  logic        started;

  always #5 clk = ~clk;

  // Clock drives the DUTs

  hs_fifo #(.DWIDTH(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .push_rdy(push_rdy4), .push_push(push_push), .push_dat(push_dat),
    .pull_rdy(pull_rdy4), .pull_pop(pull_pop), .pull_dat(pull_dat4),
    .level(level4)
`ifdef HS_FIFO_ERR_EN
    , .ovf(ovf4), .udf(udf4)
`endif
  );

  hs_fifo #(.DWIDTH(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .push_rdy(push_rdy3), .push_push(push_push), .push_dat(push_dat),
    .pull_rdy(pull_rdy3), .pull_pop(pull_pop), .pull_dat(pull_dat3),
    .level(level3)
`ifdef HS_FIFO_ERR_EN
    , .ovf(ovf3), .udf(udf3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Assert reset asynchronously, check cleared state at once, release after two edges.
  task automatic do_reset();
    rst_n = 1'b0;
    push_push = 1'b0;
    pull_pop = 1'b0;
    #1;
    chk("rst_push_rdy4", push_rdy4, 0);
    chk("rst_pull_rdy4", pull_rdy4, 0);
    chk("rst_level4", level4, 0);
    chk("rst_push_rdy3", push_rdy3, 0);
    chk("rst_pull_rdy3", pull_rdy3, 0);
    chk("rst_level3", level3, 0);
`ifdef HS_FIFO_ERR_EN
    chk("rst_ovf4", ovf4, 0);
    chk("rst_udf4", udf4, 0);
    chk("rst_ovf3", ovf3, 0);
    chk("rst_udf3", udf3, 0);
    ovf_m4 = 0; udf_m4 = 0; ovf_m3 = 0; udf_m3 = 0;
`endif
    q4.delete();
    q3.delete();
    started = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: apply inputs, check visible state against the model, then advance the model.
  task automatic cyc(input logic pu, input logic [31:0] d, input logic po);
    int s4, s3;
    logic r4, r3, pa4, pp4, pa3, pp3;
    push_push = pu;
    push_dat  = d;
    pull_pop  = po;
    s4 = q4.size();
    s3 = q3.size();
    r4 = started && (s4 != 4);
    r3 = started && (s3 != 3);
    chk("push_rdy4", push_rdy4, r4);
    chk("pull_rdy4", pull_rdy4, s4 != 0);
    chk("level4", level4, s4);
    if (s4 > 0) chk("pull_dat4", pull_dat4, q4[0]);
    chk("push_rdy3", push_rdy3, r3);
    chk("pull_rdy3", pull_rdy3, s3 != 0);
    chk("level3", level3, s3);
    if (s3 > 0) chk("pull_dat3", pull_dat3, q3[0]);
`ifdef HS_FIFO_ERR_EN
    chk("ovf4", ovf4, ovf_m4);
    chk("udf4", udf4, udf_m4);
    chk("ovf3", ovf3, ovf_m3);
    chk("udf3", udf3, udf_m3);
`endif
    pa4 = pu && r4;
    pp4 = po && (s4 != 0);
    pa3 = pu && r3;
    pp3 = po && (s3 != 0);
    @(posedge clk);
    if (pp4) void'(q4.pop_front());
    if (pa4) q4.push_back(d);
    if (pp3) void'(q3.pop_front());
    if (pa3) q3.push_back(d);
`ifdef HS_FIFO_ERR_EN
    if (pu && !r4) ovf_m4 = 1;
    if (po && s4 == 0) udf_m4 = 1;
    if (pu && !r3) ovf_m3 = 1;
    if (po && s3 == 0) udf_m3 = 1;
`endif
    started = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();

    // Power-up: push_rdy low in cycle 0, high afterwards, nothing stored.
    repeat (3) cyc(0, 32'h0, 0);

    // Fill with four words, then an extra push that must be ignored by a full FIFO.
    cyc(1, 32'h11, 0);
    cyc(1, 32'h22, 0);
    cyc(1, 32'h33, 0);
    cyc(1, 32'h44, 0);
    cyc(1, 32'h55, 0);
    cyc(0, 32'h0, 0);
    chk("full_level4", level4, 4);

    // Drain in order, then one pop on an empty FIFO.
    repeat (5) cyc(0, 32'h0, 1);
    cyc(0, 32'h0, 0);
    chk("empty_level4", level4, 0);

    // Two words resident, then ten simultaneous push/pop cycles across the pointer wrap.
    cyc(1, 32'hA0, 0);
    cyc(1, 32'hA1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'(i), 1);
    chk("steady_level4", level4, 2);
    chk("steady_head4", pull_dat4, 8);
    repeat (4) cyc(0, 32'h0, 1);

    // Overflow then underflow attempts, followed by a reset that clears everything.
    for (int i = 0; i < 5; i++) cyc(1, 32'hC0 + 32'(i), 0);
    cyc(0, 32'h0, 0);
    repeat (5) cyc(0, 32'h0, 1);
    repeat (3) cyc(0, 32'h0, 0);
    do_reset();
    cyc(0, 32'h0, 0);

    // Random traffic with 50% push and 50% pop probability.
    for (int i = 0; i < 2000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      if (i == 1500) do_reset();
    end
    cyc(0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
